// File: rtl/demux_stream_1xn.sv
// rtl/demux_stream_1xn.sv - registered ready/valid 1-to-N stream demultiplexer
// Optional broadcast input (in_bcast) is compiled in when DEMUX_STREAM_BCAST_EN is defined.
module demux_stream_1xn #(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
`ifdef DEMUX_STREAM_BCAST_EN
  input  logic                      in_bcast,
`endif
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      sel_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e           ch_state_q [CHANNELS];
  ch_state_e           ch_state_d [CHANNELS];
  logic [WIDTH-1:0]    data_q     [CHANNELS];
  logic [WIDTH-1:0]    data_d     [CHANNELS];
  logic                sel_err_q;
  logic                sel_err_d;

  logic                sel_ok;
  logic                bcast;
  logic                accept;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] can_take;
  logic [CHANNELS-1:0] load;

`ifdef DEMUX_STREAM_BCAST_EN
  assign bcast = in_bcast;
`else
  assign bcast = 1'b0;
`endif

  // Out-of-range selects only exist when CHANNELS is not a power of two.
  generate
    if ((1 << SEL_W) == CHANNELS) begin : g_sel_pow2
      assign sel_ok = 1'b1;
    end else begin : g_sel_npow2
      assign sel_ok = (32'(in_sel) < 32'(CHANNELS));
    end
  endgenerate

  always_comb begin
    hit      = '0;
    can_take = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      can_take[i] = (ch_state_q[i] == EMPTY) || out_ready[i];
      hit[i]      = bcast || (sel_ok && (in_sel == SEL_W'(i)));
    end
  end

  // A discarded (bad-select) beat is always taken so the producer never deadlocks.
  always_comb begin
    if (bcast) begin
      in_ready = &can_take;
    end else begin
      in_ready = !sel_ok || |(hit & can_take);
    end
  end

  assign accept    = in_valid && in_ready;
  assign load      = accept ? hit : '0;
  assign sel_err_d = accept && !sel_ok && !bcast;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      ch_state_d[i] = ch_state_q[i];
      data_d[i]     = data_q[i];
      unique case (ch_state_q[i])
        EMPTY: begin
          if (load[i]) begin
            ch_state_d[i] = FULL;
            data_d[i]     = in_data;
          end
        end
        FULL: begin
          // Drain and reload in the same cycle keeps the channel full with no bubble.
          if (load[i]) begin
            data_d[i] = in_data;
          end else if (out_ready[i]) begin
            ch_state_d[i] = EMPTY;
          end
        end
        default: ch_state_d[i] = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        ch_state_q[i] <= EMPTY;
        data_q[i]     <= '0;
      end
      sel_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        ch_state_q[i] <= ch_state_d[i];
        data_q[i]     <= data_d[i];
      end
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      out_valid[i]               = (ch_state_q[i] == FULL);
      out_data[i*WIDTH +: WIDTH] = data_q[i];
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_demux_stream_1xn.sv
// tb/tb_demux_stream_1xn.sv - bench for demux_stream_1xn (8- and 6-channel instances)
module tb_demux_stream_1xn;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        v8    = 1'b0;
  logic        v6    = 1'b0;
  logic        bcast = 1'b0;
  logic [7:0]  din   = 8'h00;
  logic [2:0]  sel   = 3'd0;
  logic [7:0]  or8   = 8'hFF;
  logic [5:0]  or6   = 6'h3F;

  logic        rdy8, rdy6, err8, err6;
  logic [7:0]  ov8;
  logic [5:0]  ov6;
  logic [63:0] od8;
  logic [47:0] od6;
  logic        bc;

  int checks   = 0;
  int failures = 0;

  bit       mv   [2][8];
  bit [7:0] md   [2][8];
  bit       merr [2];
  int       nch  [2] = '{8, 6};

`ifdef DEMUX_STREAM_BCAST_EN
  assign bc = bcast;
`else
  assign bc = 1'b0;
`endif

  demux_stream_1xn #(.WIDTH(8), .CHANNELS(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8), .in_data(din), .in_sel(sel),
`ifdef DEMUX_STREAM_BCAST_EN
    .in_bcast(bcast),
`endif
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .sel_err(err8)
  );

  demux_stream_1xn #(.WIDTH(8), .CHANNELS(6)) u6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v6), .in_ready(rdy6), .in_data(din), .in_sel(sel),
`ifdef DEMUX_STREAM_BCAST_EN
    .in_bcast(bcast),
`endif
    .out_valid(ov6), .out_ready(or6), .out_data(od6), .sel_err(err6)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] orv(int k);
    return (k == 0) ? or8 : {2'b00, or6};
  endfunction

  // A channel can take a beat if it is empty or its consumer is draining it.
  function automatic bit m_ready(int k, bit b, int s, logic [7:0] o);
    bit r;
    r = 1'b1;
    if (b) begin
      for (int i = 0; i < nch[k]; i++) r = r && (!mv[k][i] || o[i]);
    end else if (s < nch[k]) begin
      r = !mv[k][s] || o[s];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        merr[k] = 1'b0;
        for (int i = 0; i < 8; i++) begin
          mv[k][i] = 1'b0;
          md[k][i] = 8'h00;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit vin;
        bit acc;
        vin = (k == 0) ? v8 : v6;
        acc = vin && m_ready(k, bc, int'(sel), orv(k));
        for (int i = 0; i < nch[k]; i++) begin
          if (acc && (bc || int'(sel) == i)) begin
            mv[k][i] = 1'b1;
            md[k][i] = din;
          end else if (orv(k) >> i & 8'h01) begin
            mv[k][i] = 1'b0;
          end
        end
        merr[k] = acc && !bc && (int'(sel) >= nch[k]);
      end
    end
  end

  task automatic cmp(int k, logic rdy, logic [7:0] ov, logic [63:0] od, logic err);
    logic [7:0]  ev;
    logic [63:0] ed;
    ev = '0;
    ed = '0;
    for (int i = 0; i < nch[k]; i++) begin
      ev[i]         = mv[k][i];
      ed[i*8 +: 8]  = md[k][i];
    end
    chk($sformatf("model k%0d in_ready", k), rdy, m_ready(k, bc, int'(sel), orv(k)));
    chk($sformatf("model k%0d out_valid", k), ov, ev);
    chk($sformatf("model k%0d out_data", k), od, ed);
    chk($sformatf("model k%0d sel_err", k), err, merr[k]);
  endtask

  always @(negedge clk) begin
    cmp(0, rdy8, ov8, od8, err8);
    cmp(1, rdy6, {2'b00, ov6}, {16'h0000, od6}, err6);
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", ov8, 0);
    chk("rst out_data", od8, 0);
    chk("rst sel_err", err8, 0);
    rst_n = 1'b1;
    #1 chk("rst in_ready", rdy8, 1);

    // single beat to channel 3
    v8 = 1; din = 8'hA5; sel = 3'd3;
    step;
    v8 = 0;
    chk("t1 out_valid", ov8, 8'h08);
    chk("t1 out_data", od8[31:24], 8'hA5);
    step;
    chk("t1 drained", ov8, 8'h00);

    // stall on channel 2
    or8[2] = 0; v8 = 1; din = 8'h11; sel = 3'd2;
    step;
    din = 8'h22;
    #1 chk("stall in_ready", rdy8, 0);
    step;
    chk("stall hold data", od8[23:16], 8'h11);
    chk("stall hold valid", ov8[2], 1);
    or8[2] = 1;
    #1 chk("stall release in_ready", rdy8, 1);
    step;
    v8 = 0;
    chk("stall reload data", od8[23:16], 8'h22);
    chk("stall reload valid", ov8, 8'h04);
    step;
    chk("stall drained", ov8, 8'h00);

    // independence: channel 5 stalled, channel 6 still flows
    or8[5] = 0; v8 = 1; din = 8'h44; sel = 3'd5;
    step;
    din = 8'h33; sel = 3'd6;
    #1 chk("indep in_ready", rdy8, 1);
    step;
    v8 = 0;
    chk("indep valid", ov8, 8'h60);
    chk("indep ch6 data", od8[55:48], 8'h33);
    chk("indep ch5 data", od8[47:40], 8'h44);
    step;
    chk("indep ch5 held", ov8, 8'h20);
    or8[5] = 1;
    step;
    chk("indep drained", ov8, 8'h00);

    // back-to-back beats to channel 0
    v8 = 1; sel = 3'd0;
    for (int b = 0; b < 16; b++) begin
      din = 8'(b);
      #1 chk($sformatf("b2b in_ready %0d", b), rdy8, 1);
      step;
      chk($sformatf("b2b data %0d", b), od8[7:0], 64'(b));
      chk($sformatf("b2b valid %0d", b), ov8, 8'h01);
    end
    v8 = 0;
    step;
    chk("b2b retained", od8[7:0], 8'h0F);

    // invalid select on the 6-channel instance
    v6 = 1; sel = 3'd7; din = 8'hFF;
    #1 chk("badsel in_ready", rdy6, 1);
    step;
    v6 = 0;
    chk("badsel sel_err", err6, 1);
    chk("badsel out_valid", ov6, 6'h00);
    step;
    chk("badsel sel_err pulse", err6, 0);
    chk("badsel out_valid after", ov6, 6'h00);
    v6 = 1; sel = 3'd5; din = 8'hC3;
    step;
    v6 = 0;
    chk("k6 ch5 valid", ov6, 6'h20);
    chk("k6 ch5 data", od6[47:40], 8'hC3);
    step;

    // async reset with channels 1 and 4 full
    or8 = 8'h00; v8 = 1; sel = 3'd1; din = 8'h71;
    step;
    sel = 3'd4; din = 8'h74;
    step;
    v8 = 0;
    chk("arst pre valid", ov8, 8'h12);
    #1 rst_n = 1'b0;
    #1;
    chk("arst out_valid", ov8, 8'h00);
    chk("arst out_data", od8, 64'h0);
    step;
    rst_n = 1'b1;
    or8 = 8'hFF;
    step;
    chk("arst after release", ov8, 8'h00);

`ifdef DEMUX_STREAM_BCAST_EN
    bcast = 1; v8 = 1; din = 8'h5A; sel = 3'd2;
    step;
    v8 = 0;
    chk("bcast valid", ov8, 8'hFF);
    chk("bcast data", od8, {8{8'h5A}});
    or8[3] = 0;
    step;
    chk("bcast ch3 held", ov8, 8'h08);
    #1 chk("bcast stalled in_ready", rdy8, 0);
    bcast = 0; or8 = 8'hFF;
    step;
`endif

    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_stream_1xn.md
Name: demux_stream_1xn

Overview:
- Registered, flow-controlled 1-to-N demultiplexer; generalises the fixed 1x8 combinational demux to WIDTH-bit data and CHANNELS outputs.
- Each output channel has a one-entry holding register with a valid/ready handshake.
- Sits between a single producer and N independent consumers.
- A back-pressured channel stalls only traffic addressed to it.

Parameters:
- WIDTH, 8, data bits per transfer.
- CHANNELS, 8, number of output channels, minimum 2.
- SEL_W, $clog2(CHANNELS), select width; derived localparam, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a transfer.
- in_ready  output  1  block accepts the transfer this cycle.
- in_data  input  WIDTH  payload.
- in_sel  input  SEL_W  destination channel index.
- out_valid  output  CHANNELS  bit i: channel i holds data.
- out_ready  input  CHANNELS  bit i: consumer i takes data.
- out_data  output  CHANNELS*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
- sel_err  output  1  one-cycle pulse: a transfer with in_sel >= CHANNELS was dropped.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid = 0, out_data = 0, sel_err = 0.
  - in_ready reflects the empty state once reset releases.
- Transfer rules:
  - Accept = in_valid && in_ready on a rising edge.
  - in_ready is combinational: 1 if in_sel >= CHANNELS, else (!out_valid[in_sel] || out_ready[in_sel]).
  - in_ready may depend on in_sel and out_ready; it must not depend on in_valid.
- Latency: data accepted in cycle t appears on out_data[in_sel] with out_valid set in cycle t+1.
- Channel i state machine, states EMPTY / FULL:
  - EMPTY -> FULL on accept to i.
  - FULL -> EMPTY on out_ready[i] with no new accept to i.
  - FULL stays FULL on simultaneous drain and accept to i: register reloads with new data, no bubble. Full throughput is 1 transfer/cycle per channel.
  - FULL && !out_ready[i]: out_data slice and out_valid[i] held stable.
- Data retention: out_data slice of an EMPTY channel retains its last value. It is zero only after reset.
- Channel independence: a stalled channel never blocks accepts to other channels.
- Other channels are unaffected by any transfer not addressed to them.
- Invalid select (in_sel >= CHANNELS, only possible when CHANNELS is not a power of 2):
  - Transfer is accepted and discarded.
  - sel_err = 1 in the next cycle only.
  - No out_valid changes.
- sel_err is registered.
- Reset mid-operation: all held data lost, all out_valid cleared immediately (asynchronously).
- Pure ready-valid stream:
  - No in_valid: no state change except drains.
  - in_data and in_sel are ignored when in_valid = 0.

Optional Feature:
- Macro: DEMUX_STREAM_BCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast = 1, in_sel is ignored and in_ready = AND over all i of (!out_valid[i] || out_ready[i]).
  - On accept, every channel loads in_data and sets out_valid next cycle.
  - sel_err is never raised for a broadcast.
- Not defined:
  - Port absent; unicast only.
  - Behaviour as above.

Test Plan:
- Reset with WIDTH=8, CHANNELS=8, all out_ready=1:
  - Send 0xA5 with sel=3.
  - Next cycle: out_valid = 8'b0000_1000 and out_data[31:24] = 0xA5.
  - The cycle after: out_valid = 0.
- Stall: out_ready[2]=0.
  - Send 0x11 then 0x22 to sel=2: second transfer sees in_ready=0.
  - Channel 2 holds 0x11 stable.
  - Raise out_ready[2]: 0x22 is accepted the same cycle and appears next cycle.
- Independence: channel 5 stalled and full.
  - Send 0x33 to sel=6 (in_ready=1).
  - Channel 6 valid with 0x33; channel 5 unchanged.
- Back-to-back: out_ready[0]=1.
  - Send 16 consecutive beats 0x00..0x0F to sel=0.
  - in_ready stays 1 throughout; outputs appear in order, one per cycle, no bubbles.
- Invalid select: CHANNELS=6.
  - Send sel=7 data 0xFF: accepted.
  - sel_err pulses exactly one cycle; out_valid stays 0.
- Async reset: assert rst_n=0 mid-cycle while channels 1 and 4 are full.
  - out_valid = 0 immediately, before the next clk edge.
  - With DEMUX_STREAM_BCAST_EN: broadcast 0x5A with all channels empty sets out_valid = all ones next cycle.
  - Broadcast with one channel stalled gives in_ready=0.
